// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, write-to-read bypass and a load-use scoreboard.
// Latency: reads 0 cycles (bypass), writes and scoreboard updates land on the next clk edge.
// Backpressure: stall is raised combinationally while a used source waits on an in-flight load.
module regfile_scoreboard #(
  parameter int N                 = 32,
  parameter int REG_FILE_SIZE     = 32,
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int NUM_RD_PORTS      = 2,
  parameter int LOAD_LATENCY      = 3,
  parameter int HARDWIRE_ZERO     = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [NUM_RD_PORTS-1:0][REG_FILE_ADDR_LEN-1:0]    rd_addr,
  input  logic [NUM_RD_PORTS-1:0]                           rd_use,
  output logic [NUM_RD_PORTS-1:0][N-1:0]                    rd_data,
  input  logic                                              wr_en,
  input  logic [REG_FILE_ADDR_LEN-1:0]                      wr_addr,
  input  logic [N-1:0]                                      wr_data,
  input  logic                                              ld_issue,
  input  logic [REG_FILE_ADDR_LEN-1:0]                      ld_dest,
  output logic                                              stall,
  output logic [$clog2(LOAD_LATENCY+1)-1:0]                 pending_cnt
);

  localparam int              CW     = $clog2(LOAD_LATENCY + 1);
  localparam logic [CW-1:0]   LAT    = CW'(LOAD_LATENCY);
  localparam logic [31:0]     SIZE_U = 32'(REG_FILE_SIZE);

  logic [N-1:0]            mem   [REG_FILE_SIZE];
  logic [CW-1:0]           cnt_q [REG_FILE_SIZE];
  logic [CW-1:0]           cnt_d [REG_FILE_SIZE];
  logic [CW-1:0]           pop_d;
  logic [NUM_RD_PORTS-1:0] byp_hit;
  logic                    wr_ok;
  logic                    iss_ok;

  // A "live" address exists in the array and is not the hardwired zero register.
  function automatic logic addr_live(input logic [REG_FILE_ADDR_LEN-1:0] a);
    return (32'(a) < SIZE_U) && !((HARDWIRE_ZERO != 0) && (a == '0));
  endfunction

  assign wr_ok  = wr_en && addr_live(wr_addr);
  assign iss_ok = ld_issue && !stall && addr_live(ld_dest);

  always_comb begin
    stall   = 1'b0;
    byp_hit = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_data[p] = '0;
      byp_hit[p] = wr_ok && (wr_addr == rd_addr[p]);
      if (addr_live(rd_addr[p])) begin
        rd_data[p] = byp_hit[p] ? wr_data : mem[rd_addr[p]];
        if (rd_use[p] && (cnt_q[rd_addr[p]] != '0) && !byp_hit[p])
          stall = 1'b1;
      end
    end
  end

  // Per-register priority: issue reload, then writeback clear, then countdown.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      if (iss_ok && (ld_dest == REG_FILE_ADDR_LEN'(i)))
        cnt_d[i] = LAT;
      else if (wr_ok && (wr_addr == REG_FILE_ADDR_LEN'(i)))
        cnt_d[i] = '0;
      else if (cnt_q[i] != '0)
        cnt_d[i] = cnt_q[i] - CW'(1);
      else
        cnt_d[i] = cnt_q[i];
      if (cnt_d[i] != '0)
        pop_d = pop_d + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        mem[i]   <= '0;
        cnt_q[i] <= '0;
      end
      pending_cnt <= '0;
    end else begin
      if (wr_ok)
        mem[wr_addr] <= wr_data;
      cnt_q       <= cnt_d;
      pending_cnt <= pop_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (LOAD_LATENCY=3, HARDWIRE_ZERO=1).
module tb_regfile_scoreboard;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][4:0] rd_addr;
  logic [1:0]      rd_use;
  logic [1:0][31:0] rd_data;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;
  logic            ld_issue;
  logic [4:0]      ld_dest;
  logic            stall;
  logic [1:0]      pending_cnt;

  int tests = 0;
  int fails = 0;

  regfile_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_use      (rd_use),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ld_issue    (ld_issue),
    .ld_dest     (ld_dest),
    .stall       (stall),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    ld_issue = 1'b0;
    rd_use   = 2'b00;
  endtask

  initial begin
    reset = 1'b1; idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; ld_dest = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_pending", 32'(pending_cnt), 32'd0);

    // Preload r5 and an in-flight load to r7, then reset over them.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    ld_issue = 1'b1; ld_dest = 5'd7;
    cyc(); idle();
    rd_addr[0] = 5'd5;
    #1;
    chk("preload_r5", rd_data[0], 32'hDEADBEEF);
    chk("preload_pending", 32'(pending_cnt), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_addr[1] = 5'd7; rd_use = 2'b11;
    #1;
    chk("post_reset_r5", rd_data[0], 32'h0);
    chk("post_reset_stall", 32'(stall), 32'd0);
    chk("post_reset_pending", 32'(pending_cnt), 32'd0);
    idle();

    // Bypass then array read of r3.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; rd_addr[1] = 5'd3;
    #1;
    chk("bypass_r3", rd_data[1], 32'h12345678);
    cyc(); idle();
    #1;
    chk("array_r3", rd_data[1], 32'h12345678);

    // Hardwired zero register.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr[0] = 5'd0;
    #1;
    chk("r0_no_bypass", rd_data[0], 32'h0);
    cyc(); idle();
    #1;
    chk("r0_array", rd_data[0], 32'h0);
    ld_issue = 1'b1; ld_dest = 5'd0;
    cyc(); idle();
    rd_use = 2'b01;
    #1;
    chk("r0_pending", 32'(pending_cnt), 32'd0);
    chk("r0_stall", 32'(stall), 32'd0);
    idle();

    // Load to r4, writeback arrives in the last pending cycle.
    ld_issue = 1'b1; ld_dest = 5'd4;
    cyc(); idle();
    rd_addr[0] = 5'd4; rd_use = 2'b01;
    #1;
    chk("r4_stall_c0", 32'(stall), 32'd1);
    chk("r4_pending_c0", 32'(pending_cnt), 32'd1);
    cyc();
    chk("r4_stall_c1", 32'(stall), 32'd1);
    cyc();
    chk("r4_stall_c2_nowb", 32'(stall), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h000000A5;
    #1;
    chk("r4_stall_c2_wb", 32'(stall), 32'd0);
    chk("r4_data_c2", rd_data[0], 32'h000000A5);
    cyc(); wr_en = 1'b0;
    #1;
    chk("r4_stall_c3", 32'(stall), 32'd0);
    chk("r4_pending_c3", 32'(pending_cnt), 32'd0);
    chk("r4_array", rd_data[0], 32'h000000A5);
    idle();

    // Load to r9 times out; r10 issue while stalled is dropped.
    ld_issue = 1'b1; ld_dest = 5'd9;
    cyc();
    rd_addr[0] = 5'd9; rd_use = 2'b01; ld_dest = 5'd10;
    #1;
    chk("r9_pending_c0", 32'(pending_cnt), 32'd1);
    chk("r9_stall_c0", 32'(stall), 32'd1);
    cyc();
    chk("r9_pending_c1", 32'(pending_cnt), 32'd1);
    chk("r9_stall_c1", 32'(stall), 32'd1);
    cyc();
    chk("r9_pending_c2", 32'(pending_cnt), 32'd1);
    chk("r9_stall_c2", 32'(stall), 32'd1);
    cyc(); ld_issue = 1'b0;
    rd_addr[1] = 5'd10; rd_use = 2'b11;
    #1;
    chk("r9_pending_c3", 32'(pending_cnt), 32'd0);
    chk("r9_r10_stall_c3", 32'(stall), 32'd0);
    idle();

    // Issue and write to r6 on the same edge: issue wins, data still lands.
    ld_issue = 1'b1; ld_dest = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h00000066;
    cyc(); idle();
    rd_addr[0] = 5'd6; rd_use = 2'b01;
    #1;
    chk("r6_pending", 32'(pending_cnt), 32'd1);
    chk("r6_stall_c0", 32'(stall), 32'd1);
    chk("r6_data", rd_data[0], 32'h00000066);
    cyc();
    chk("r6_stall_c1", 32'(stall), 32'd1);
    cyc();
    chk("r6_stall_c2", 32'(stall), 32'd1);
    cyc();
    chk("r6_stall_c3", 32'(stall), 32'd0);
    idle();

    // Back-to-back loads to r8 reload the countdown.
    ld_issue = 1'b1; ld_dest = 5'd8;
    cyc(); cyc(); idle();
    cyc(); cyc();
    chk("r8_reload_pending", 32'(pending_cnt), 32'd1);
    cyc();
    chk("r8_reload_done", 32'(pending_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
